cnn_cell_update: RTL and testbench



---
 rtl/cnn_cell_update_if.sv | 11 +
 rtl/cnn_cell_update.sv | 137 +++++++++++++
 tb/tb_cnn_cell_update.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_cell_update_if.sv
// Template-sum handshake between the MAC stage (master) and the cell update stage (slave).
interface cnn_cell_update_if #(
    parameter int WIDTH = 9
);
    logic                      sum_valid;
    logic                      sum_ready;
    logic signed [2*WIDTH-1:0] sum_in;

    modport master (output sum_valid, output sum_in, input sum_ready);
    modport slave  (input sum_valid, input sum_in, output sum_ready);
endinterface

// File: rtl/cnn_cell_update.sv
// CNN cell state integrator: forward-Euler update of x, saturated output y.
// Optional CNN_EARLY_EXIT_EN: finish the run as soon as an Euler step is zero.
module cnn_cell_update #(
    parameter int WIDTH      = 9,
    parameter int FRAC       = 4,
    parameter int STEP_SHIFT = 3,
    parameter int XW         = WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_init,
    input  logic [7:0]              iter_limit,
    cnn_cell_update_if.slave        sum_bus,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [XW-1:0]    x_out,
    output logic [7:0]              iter_count,
    output logic                    busy,
    output logic                    done
);
    localparam int SW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT_SUM, UPDATE, DONE} state_t;

    localparam logic signed [SW-1:0]    S_MAX = SW'((1 << (XW - 1)) - 1);
    localparam logic signed [SW-1:0]    S_MIN = ~S_MAX;
    localparam logic signed [XW-1:0]    X_MAX = {1'b0, {(XW-1){1'b1}}};
    localparam logic signed [XW-1:0]    X_MIN = {1'b1, {(XW-1){1'b0}}};
    localparam logic signed [XW-1:0]    ONE_X = XW'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] ONE_Y = WIDTH'(1 << FRAC);

    state_t                  state;
    logic signed [XW-1:0]    x;
    logic signed [XW-1:0]    s;
    logic [7:0]              lim;
    logic                    ready;

    logic signed [SW-1:0]    sum_sh;
    logic signed [XW-1:0]    s_next;
    logic signed [XW:0]      diff;
    logic signed [XW:0]      d;
    logic signed [XW:0]      x_sum;
    logic signed [XW-1:0]    x_next;
    logic                    stop;

    assign sum_bus.sum_ready = ready;
    assign x_out             = x;

    always_comb begin
        y_out = x[WIDTH-1:0];
        if (x > ONE_X)
            y_out = ONE_Y;
        else if (x < -ONE_X)
            y_out = -ONE_Y;
    end

    // Sum carries 2*FRAC fraction bits; drop FRAC and clamp into the state range.
    always_comb begin
        sum_sh = sum_bus.sum_in >>> FRAC;
        s_next = sum_sh[XW-1:0];
        if (sum_sh > S_MAX)
            s_next = X_MAX;
        else if (sum_sh < S_MIN)
            s_next = X_MIN;
    end

    // One extra bit keeps s - x and x + d exact before saturating back to XW.
    always_comb begin
        diff   = {s[XW-1], s} - {x[XW-1], x};
        d      = diff >>> STEP_SHIFT;
        x_sum  = {x[XW-1], x} + d;
        x_next = x_sum[XW-1:0];
        if (x_sum[XW] != x_sum[XW-1])
            x_next = x_sum[XW] ? X_MIN : X_MAX;
    end

`ifdef CNN_EARLY_EXIT_EN
    assign stop = (iter_count + 8'd1 == lim) || (d == '0);
`else
    assign stop = (iter_count + 8'd1 == lim);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            s          <= '0;
            lim        <= '0;
            iter_count <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x          <= XW'(x_init);
                        iter_count <= '0;
                        lim        <= iter_limit;
                        busy       <= 1'b1;
                        if (iter_limit == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_SUM;
                            ready <= 1'b1;
                        end
                    end
                end
                WAIT_SUM: begin
                    if (sum_bus.sum_valid) begin
                        s     <= s_next;
                        ready <= 1'b0;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    x          <= x_next;
                    iter_count <= iter_count + 8'd1;
                    if (stop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= WAIT_SUM;
                        ready <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_cell_update.sv
// Scoreboard bench for cnn_cell_update: reference Euler model feeds an expected-result queue.
module tb_cnn_cell_update;
    localparam int WIDTH = 9;
    localparam int XW    = WIDTH + 4;
`ifdef CNN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int cnt;
        bit done;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic signed [WIDTH-1:0] x_init = '0;
    logic [7:0]              iter_limit = '0;
    logic signed [WIDTH-1:0] y_out;
    logic signed [XW-1:0]    x_out;
    logic [7:0]              iter_count;
    logic                    busy;
    logic                    done;

    cnn_cell_update_if #(.WIDTH(WIDTH)) sbus ();

    cnn_cell_update dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_init     (x_init),
        .iter_limit (iter_limit),
        .sum_bus    (sbus),
        .y_out      (y_out),
        .x_out      (x_out),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   mx, mcnt, mlim;
    bit   mdone;
    bit   acc = 1'b0;
    bit   upd = 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int lo, input int hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic int ysat(input int v);
        return sat(v, -16, 16);
    endfunction

    // x_out of an accepted sum is valid two edges after acceptance.
    always @(posedge clk) begin
        upd <= acc && !reset;
        acc <= sbus.sum_valid && sbus.sum_ready && !reset;
    end

    always @(negedge clk) begin
        if (upd) begin
            chk("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("step_x", $signed(x_out), e.x);
                chk("step_y", $signed(y_out), e.y);
                chk("step_cnt", iter_count, e.cnt);
                chk("step_done", done, e.done);
            end
        end
    end

    task automatic run_start(input int xi, input int lim);
        start      = 1'b1;
        x_init     = WIDTH'(xi);
        iter_limit = 8'(lim);
        @(posedge clk);
        #1 start = 1'b0;
        mx    = xi;
        mcnt  = 0;
        mlim  = lim;
        mdone = (lim == 0);
        @(negedge clk);
        chk("start_x", $signed(x_out), xi);
        chk("start_busy", busy, 1);
        chk("start_ready", sbus.sum_ready, (lim == 0) ? 0 : 1);
    endtask

    task automatic do_step(input int sum);
        int   n = 0;
        int   sv, dv;
        exp_t e;
        sbus.sum_valid = 1'b1;
        sbus.sum_in    = (2*WIDTH)'(sum);
        while (!sbus.sum_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sbus.sum_ready) begin
            chk("sum_accept_timeout", 0, 1);
            sbus.sum_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 sbus.sum_valid = 1'b0;
        sv    = sat(sum >>> 4, -4096, 4095);
        dv    = (sv - mx) >>> 3;
        mx    = sat(mx + dv, -4096, 4095);
        mcnt  = mcnt + 1;
        mdone = (mcnt == mlim) || (EARLY && dv == 0);
        e.x = mx; e.y = ysat(mx); e.cnt = mcnt; e.done = mdone;
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_steps(input int sum, input int max_n);
        for (int i = 0; i < max_n; i++)
            if (!mdone) do_step(sum);
    endtask

    task automatic check_idle_after_done(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_x"}, $signed(x_out), mx);
        chk({tag, "_cnt"}, iter_count, mcnt);
    endtask

    initial begin
        sbus.sum_valid = 1'b0;
        sbus.sum_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_y", $signed(y_out), 0);
        chk("rst_x", $signed(x_out), 0);
        chk("rst_cnt", iter_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", sbus.sum_ready, 0);
        reset = 1'b0;
        @(negedge clk);

        run_start(0, 1);
        do_step(2048);
        chk("single_x", $signed(x_out), 16);
        chk("single_done", done, 1);
        check_idle_after_done("single");

        run_start(40, 1);
        chk("pos_sat_y", $signed(y_out), 16);
        do_step(640);
        check_idle_after_done("pos_sat");

        run_start(-40, 20);
        chk("neg_sat_y", $signed(y_out), -16);
        run_steps(131071, 20);
        check_idle_after_done("big_pos");

        run_start(0, 5);
        run_steps(-131072, 5);
        check_idle_after_done("big_neg");

        run_start(25, 0);
        chk("zero_done", done, 1);
        chk("zero_y", $signed(y_out), 16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_ready", sbus.sum_ready, 0);
            chk("zero_x", $signed(x_out), 25);
        end

        run_start(0, 1);
        do_step(-16);
        chk("floor_x", $signed(x_out), -1);
        check_idle_after_done("floor");

        run_start(0, 4);
        run_steps(112, 4);
        chk("d0_cnt", iter_count, EARLY ? 1 : 4);
        check_idle_after_done("d0");

        run_start(5, 3);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                start = 1'b1;
                x_init = 9'sd99;
                iter_limit = 8'd1;
            end
            if (i == 6) start = 1'b0;
            @(negedge clk);
            chk("bp_ready", sbus.sum_ready, 1);
            chk("bp_busy", busy, 1);
            chk("bp_x", $signed(x_out), 5);
            chk("bp_cnt", iter_count, 0);
        end
        start = 1'b0;
        run_steps(800, 3);
        chk("bp_final_done", done, 1);
        start = 1'b1;
        x_init = 9'sd77;
        iter_limit = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("done_start_busy", busy, 0);
        chk("done_start_x", $signed(x_out), mx);
        chk("done_start_cnt", iter_count, mcnt);

        run_start(10, 8);
        run_steps(-900, 3);
        chk("abort_pre_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mx = 0; mcnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_busy", busy, 0);
            chk("abort_cnt", iter_count, 0);
            chk("abort_x", $signed(x_out), 0);
            chk("abort_done", done, 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
